// File: rtl/bfis_query_frontend_if.sv
// Host/core/result signal bundle for the bfis query front end.
// slave  : the front end itself
// master : whoever drives the host stream, the core results and the result pops
interface bfis_query_frontend_if #(
  parameter int DIM   = 4,
  parameter int WIDTH = 32
);
  // host word stream
  logic [WIDTH-1:0]     word_in;
  logic                 word_valid_in;
  // parsed query towards the core
  logic [DIM*WIDTH-1:0] query_out;
  logic [15:0]          k_out;
  logic [WIDTH-1:0]     vertex_id_out;
  logic                 start_out;
  // core result stream
  logic [WIDTH-1:0]     core_data_in;
  logic                 core_valid_in;
  // result drain towards the host
  logic [WIDTH-1:0]     res_data_out;
  logic                 res_valid_out;
  logic                 res_ready_in;
  // status
  logic [WIDTH-1:0]     cycles_out;
  logic                 busy_out;
  logic                 k_clamped_out;
  logic [1:0]           state_out;

  modport slave (
    input  word_in, word_valid_in, core_data_in, core_valid_in, res_ready_in,
    output query_out, k_out, vertex_id_out, start_out, res_data_out,
           res_valid_out, cycles_out, busy_out, k_clamped_out, state_out
  );

  modport master (
    output word_in, word_valid_in, core_data_in, core_valid_in, res_ready_in,
    input  query_out, k_out, vertex_id_out, start_out, res_data_out,
           res_valid_out, cycles_out, busy_out, k_clamped_out, state_out
  );
endinterface

// File: rtl/bfis_query_frontend.sv
// Front end for the bfis search core: parses one framed query from the host
// stream, kicks the core, collects up to k result ids while timing the core,
// then lets the host drain the results in arrival order.
module bfis_query_frontend #(
  parameter int               DIM        = 4,
  parameter int               K_MAX      = 8,
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] START_WORD = {WIDTH{1'b1}}
) (
  input logic                 clk_in,
  input logic                 rst_in,
  bfis_query_frontend_if.slave bus
);

  localparam int CW = $clog2(DIM + 2);   // word counter covers 0..DIM+1
  localparam int AW = $clog2(K_MAX);     // buffer address
  localparam int NW = AW + 1;            // buffer occupancy 0..K_MAX

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [DIM-1:0][WIDTH-1:0]   query_q;
  logic [15:0]                 k_q;
  logic                        clamp_q;
  logic [WIDTH-1:0]            vid_q;
  logic                        start_q;
  logic [WIDTH-1:0]            lat_q;
  logic [WIDTH-1:0]            cycles_q;
  logic [WIDTH-1:0]            buf_q [K_MAX];
  logic [NW-1:0]               n_q;      // stored count in RUN, remaining count in DRAIN
  logic [AW-1:0]               rd_q;
  logic [WIDTH-1:0]            res_data_q;
  logic                        res_valid_q;

  logic                        marker;
  logic [15:0]                 k_raw;
  logic                        push;
  logic                        pop;
  logic [WIDTH-1:0]            lat_d;

  assign marker = bus.word_valid_in && (bus.word_in == START_WORD);
  assign k_raw  = bus.word_in[15:0];
  // RUN always leaves on the k-th push, so a push can never overflow the buffer
  assign push   = (state_q == RUN) && bus.core_valid_in;
  assign pop    = (state_q == DRAIN) && res_valid_q && bus.res_ready_in;
  assign lat_d  = (&lat_q) ? lat_q : lat_q + WIDTH'(1);

  // Result storage; contents are don't-care until counted in, so no reset.
  always_ff @(posedge clk_in) begin
    if (push) buf_q[n_q[AW-1:0]] <= bus.core_data_in;
  end

  // Control FSM with all outputs held in registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      query_q     <= '0;
      k_q         <= '0;
      clamp_q     <= 1'b0;
      vid_q       <= '0;
      start_q     <= 1'b0;
      lat_q       <= '0;
      cycles_q    <= '0;
      n_q         <= '0;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (marker) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end
        end

        LOAD: begin
          if (marker) begin
            cnt_q <= '0;                       // restart the frame
          end else if (bus.word_valid_in) begin
            if (cnt_q < CW'(DIM)) begin
              for (int i = 0; i < DIM; i++)
                if (cnt_q == CW'(i)) query_q[i] <= bus.word_in;
              cnt_q <= cnt_q + CW'(1);
            end else if (cnt_q == CW'(DIM)) begin
              if (k_raw == 16'd0 || k_raw > 16'(K_MAX)) begin
                k_q     <= 16'(K_MAX);
                clamp_q <= 1'b1;
              end else begin
                k_q     <= k_raw;
                clamp_q <= 1'b0;
              end
              cnt_q <= cnt_q + CW'(1);
            end else begin
              vid_q   <= bus.word_in;
              state_q <= RUN;
              start_q <= 1'b1;
              lat_q   <= '0;                   // zero during the start pulse
              n_q     <= '0;
            end
          end
        end

        RUN: begin
          lat_q <= lat_d;
          if (bus.core_valid_in) begin
            n_q <= n_q + NW'(1);
            if (16'(n_q) + 16'd1 == k_q) begin
              cycles_q    <= lat_q;
              state_q     <= DRAIN;
              rd_q        <= '0;
              res_valid_q <= 1'b1;
              // with k=1 the head is the word being pushed right now
              res_data_q  <= (n_q == '0) ? bus.core_data_in : buf_q[0];
            end
          end
        end

        DRAIN: begin
          if (pop) begin
            n_q  <= n_q - NW'(1);
            rd_q <= rd_q + AW'(1);
            if (n_q == NW'(1)) begin
              res_valid_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              res_data_q <= buf_q[rd_q + AW'(1)];
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.query_out     = query_q;
  assign bus.k_out         = k_q;
  assign bus.vertex_id_out = vid_q;
  assign bus.start_out     = start_q;
  assign bus.res_data_out  = res_data_q;
  assign bus.res_valid_out = res_valid_q;
  assign bus.cycles_out    = cycles_q;
  assign bus.busy_out      = (state_q == LOAD) || (state_q == RUN);
  assign bus.k_clamped_out = clamp_q;
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_bfis_query_frontend.sv
// Scoreboard bench for bfis_query_frontend: frames and core results are
// generated by the stimulus process, expected result ids are queued, and a
// free-running monitor checks every pop.
module tb_bfis_query_frontend;
  localparam int DIM = 4, K_MAX = 8, W = 32;
  localparam logic [W-1:0] SW = {W{1'b1}};

  typedef logic [W-1:0] wq_t[$];
  typedef int iq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bfis_query_frontend_if #(.DIM(DIM), .WIDTH(W)) bus();

  bfis_query_frontend #(.DIM(DIM), .K_MAX(K_MAX), .WIDTH(W), .START_WORD(SW)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );

  int tests = 0, fails = 0;
  logic [W-1:0] sb[$];

  // expectations from the reference model
  logic [DIM*W-1:0] exp_query;
  logic [15:0]      exp_k;
  logic             exp_clamp;
  logic [W-1:0]     exp_vid;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] nsw();
    logic [W-1:0] w;
    w = $urandom;
    if (w == SW) w = '0;
    return w;
  endfunction

  // Frame meaning: payload follows the last marker: DIM query words, k, vertex id.
  task automatic model_frame(input wq_t f);
    int s;
    logic [15:0] kw;
    s = 0;
    foreach (f[i]) if (f[i] == SW) s = i;
    for (int i = 0; i < DIM; i++) exp_query[i*W +: W] = f[s+1+i];
    kw        = f[s+1+DIM][15:0];
    exp_clamp = (kw == 0) || (kw > K_MAX);
    exp_k     = exp_clamp ? 16'(K_MAX) : kw;
    exp_vid   = f[s+2+DIM];
  endtask

  // Monitor: every pop is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.state_out != 2'd3) chk("res_valid_outside_drain", bus.res_valid_out, 0);
        if (bus.res_valid_out && bus.res_ready_in) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_pop: got %0h expected none", bus.res_data_out);
          end else begin
            chk("pop_data", bus.res_data_out, sb.pop_front());
          end
        end
      end
    end
  end

  task automatic send_frame(input wq_t f, input bit gaps);
    bit seen;
    seen = 0;
    foreach (f[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        bus.word_valid_in = 1'b0;
        bus.word_in       = $urandom;
      end
      @(posedge clk); #1;
      bus.word_in       = f[i];
      bus.word_valid_in = 1'b1;
      @(negedge clk);
      if (seen) chk("state_load", bus.state_out, 1);
      if (f[i] == SW) seen = 1;
    end
    @(posedge clk); #1;
    bus.word_valid_in = 1'b0;
    bus.word_in       = '0;
  endtask

  // One full query: frame, core results at given offsets from start, drain.
  task automatic run_query(input wq_t f, input wq_t ids, input iq_t offs,
                           input int ready_mode, input bit noise, input bit gaps);
    int kn, maxc, j, left, n;
    logic [W-1:0] exp_cyc;
    bit rdy;
    model_frame(f);
    kn      = int'(exp_k);
    exp_cyc = W'(offs[kn-1]);
    for (int i = 0; i < kn; i++) sb.push_back(ids[i]);
    send_frame(f, gaps);

    @(negedge clk);
    chk("start_pulse", bus.start_out, 1);
    chk("state_run", bus.state_out, 2);
    chk("busy_run", bus.busy_out, 1);
    chk("query", bus.query_out, exp_query);
    chk("k_out", bus.k_out, exp_k);
    chk("k_clamped", bus.k_clamped_out, exp_clamp);
    chk("vertex_id", bus.vertex_id_out, exp_vid);

    maxc = offs[offs.size()-1];
    if (maxc < 1) maxc = 1;
    j = 0;
    for (int c = 0; c <= maxc; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (j < offs.size() && offs[j] == c) begin
        bus.core_valid_in = 1'b1;
        bus.core_data_in  = ids[j];
        j++;
      end else begin
        bus.core_valid_in = 1'b0;
        bus.core_data_in  = $urandom;
      end
      if (c == 1) begin
        @(negedge clk);
        chk("start_one_cycle", bus.start_out, 0);
      end
    end
    @(posedge clk); #1;
    bus.core_valid_in = 1'b0;

    @(negedge clk);
    chk("state_drain", bus.state_out, 3);
    chk("cycles_out", bus.cycles_out, exp_cyc);
    chk("res_valid_drain", bus.res_valid_out, 1);

    left = kn;
    n    = 0;
    while (left > 0 && n < 400) begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.res_ready_in = rdy;
      if (noise) begin
        bus.word_valid_in = 1'b1;
        bus.word_in       = SW;
      end
      n++;
      @(negedge clk);
      if (bus.res_valid_out) begin
        if (rdy) left--;
        else if (sb.size() > 0) chk("head_hold", bus.res_data_out, sb[0]);
      end
    end
    if (left > 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d left expected 0", left);
    end
    @(posedge clk); #1;
    bus.res_ready_in  = 1'b0;
    bus.word_valid_in = 1'b0;
    @(negedge clk);
    chk("state_idle", bus.state_out, 0);
    chk("res_valid_idle", bus.res_valid_out, 0);
    chk("busy_idle", bus.busy_out, 0);
    chk("query_held", bus.query_out, exp_query);
    chk("cycles_held", bus.cycles_out, exp_cyc);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, bus.state_out, 0);
    chk({tag, "_query"}, bus.query_out, 0);
    chk({tag, "_k"}, bus.k_out, 0);
    chk({tag, "_vid"}, bus.vertex_id_out, 0);
    chk({tag, "_cycles"}, bus.cycles_out, 0);
    chk({tag, "_res_valid"}, bus.res_valid_out, 0);
    chk({tag, "_res_data"}, bus.res_data_out, 0);
    chk({tag, "_busy"}, bus.busy_out, 0);
    chk({tag, "_clamp"}, bus.k_clamped_out, 0);
    chk({tag, "_start"}, bus.start_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t f, ids;
    iq_t offs;
    int kn, nres, o;

    bus.word_in = '0; bus.word_valid_in = 1'b0;
    bus.core_data_in = '0; bus.core_valid_in = 1'b0;
    bus.res_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // basic frame, latency 10
    f = '{SW, 5, 7, 1, 1, 4, 1};
    ids = '{9, 3, 6, 2}; offs = '{3, 5, 6, 10};
    run_query(f, ids, offs, 0, 0, 0);

    // marker inside LOAD restarts the frame; result on the start cycle
    f = '{SW, 5, 7, SW, 1, 2, 3, 4, 2, 8};
    ids = '{11, 12}; offs = '{0, 2};
    run_query(f, ids, offs, 0, 0, 0);

    // k=1 answered on the start cycle -> zero latency, extra strobe dropped
    f = '{SW, 21, 22, 23, 24, 1, 99};
    ids = '{77, 78}; offs = '{0, 1};
    run_query(f, ids, offs, 0, 0, 0);

    // k above K_MAX clamps; ten results, eight stored
    f = '{SW, 1, 2, 3, 4, 20, 5};
    ids = '{100, 101, 102, 103, 104, 105, 106, 107, 108, 109};
    offs = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    run_query(f, ids, offs, 0, 0, 0);

    // next frame in range clears the clamp flag; alternate ready with host noise
    f = '{SW, 9, 8, 7, 6, 3, 2};
    ids = '{31, 32, 33}; offs = '{2, 4, 7};
    run_query(f, ids, offs, 1, 1, 0);

    // four results drained on alternate cycles while markers arrive
    f = '{SW, 5, 7, 1, 1, 4, 1};
    ids = '{9, 3, 6, 2}; offs = '{3, 5, 6, 10};
    run_query(f, ids, offs, 1, 1, 0);

    // reset during RUN after two results
    f = '{SW, 4, 3, 2, 1, 4, 6};
    send_frame(f, 0);
    @(negedge clk);
    chk("rst_case_start", bus.start_out, 1);
    @(posedge clk); #1;
    bus.core_valid_in = 1'b1; bus.core_data_in = 55;
    @(posedge clk); #1;
    bus.core_data_in = 56;
    @(posedge clk); #1;
    bus.core_valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrun_reset");
    repeat (3) begin
      @(negedge clk);
      chk("no_res_after_reset", bus.res_valid_out, 0);
    end

    // fresh frame after reset
    f = '{SW, 10, 20, 30, 40, 2, 3};
    ids = '{61, 62}; offs = '{1, 3};
    run_query(f, ids, offs, 0, 0, 0);

    // randomized frames
    for (int t = 0; t < 25; t++) begin
      f = {};
      repeat ($urandom_range(0, 2)) f.push_back(nsw());
      f.push_back(SW);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, DIM + 1)) f.push_back(nsw());
        f.push_back(SW);
      end
      for (int i = 0; i < DIM; i++) f.push_back(nsw());
      if ($urandom_range(0, 4) == 0) f.push_back({16'($urandom), 16'($urandom_range(9, 16'hFFFE))});
      else f.push_back({16'($urandom), 16'($urandom_range(0, 12))});
      f.push_back(nsw());
      model_frame(f);
      kn   = int'(exp_k);
      nres = kn + int'($urandom_range(0, 3));
      ids = {}; offs = {};
      o = int'($urandom_range(0, 1));
      for (int i = 0; i < nres; i++) begin
        ids.push_back($urandom);
        offs.push_back(o);
        o += int'($urandom_range(1, 4));
      end
      run_query(f, ids, offs, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bfis_query_frontend.md
Name: bfis_query_frontend

Overview:
Host-side front end for the bfis search core. Parses a framed word stream into one query: START_WORD marker, then DIM query words, then k, then vertex id. Issues a one-cycle start pulse to the core and buffers up to K_MAX result ids. Measures core latency in cycles and lets the host drain results with a valid/ready handshake. It replaces the ad-hoc loader, cycle counter and output FIFO glue in the top level.

Parameters:
DIM, 4, query vector length in words (>=1)
K_MAX, 8, result buffer depth and maximum k (power of 2, >=2)
WIDTH, 32, word width (>=16)
START_WORD, all ones of WIDTH, frame start marker

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
word_in  in  WIDTH  host stream word
word_valid_in  in  1  one-cycle strobe per host word
query_out  out  DIM*WIDTH  query vector; word i at bits [i*WIDTH +: WIDTH]
k_out  out  16  effective k after clamping
vertex_id_out  out  WIDTH  entry vertex id
start_out  out  1  one-cycle pulse to core
core_data_in  in  WIDTH  core result id
core_valid_in  in  1  core result strobe
res_data_out  out  WIDTH  head of result buffer
res_valid_out  out  1  head valid
res_ready_in  in  1  host pops head when high together with res_valid_out
cycles_out  out  WIDTH  latency of last completed query
busy_out  out  1  high in LOAD or RUN
k_clamped_out  out  1  sticky: last query's k was 0 or above K_MAX
state_out  out  2  IDLE=0, LOAD=1, RUN=2, DRAIN=3

Behaviour:
- Reset: state IDLE; all outputs 0 (query_out, k_out, vertex_id_out, cycles_out, flags, res_*); buffer emptied; word counter 0. Reset mid-operation aborts any query with no start_out and no partial results.
- A word is accepted only on a cycle where word_valid_in is high.
- IDLE: a word equal to START_WORD goes to LOAD with counter 0. Other words are ignored.
- LOAD:
  - Words 0..DIM-1 are written to query slots.
  - Word DIM is k. Its low 16 bits are used.
  - Word DIM+1 is the vertex id. On acceptance, register vertex_id_out and go to RUN. start_out is high on the following cycle, for exactly one cycle.
  - START_WORD inside LOAD restarts the frame: counter goes to 0 and state stays LOAD. START_WORD therefore cannot appear as a payload word.
  - query_out, k_out and vertex_id_out update as words arrive and hold until the next frame overwrites them.
- k rule: k=0 or k>K_MAX gives k_out=K_MAX and k_clamped_out=1. Otherwise k_out=k and k_clamped_out=0. Evaluated when word DIM is accepted.
- RUN:
  - Host words are ignored.
  - Each core_valid_in pushes core_data_in until k_out results are stored. Further strobes are dropped.
  - The latency counter is 0 on the start_out cycle and increments every cycle after it, saturating at all ones.
  - On the cycle the k-th result is pushed, cycles_out is set to the counter value (result at t+N after start at t gives N). State then goes to DRAIN.
  - A result on the same cycle as start_out is accepted, giving cycles_out=0.
- DRAIN:
  - Buffer is a FIFO in arrival order. res_data_out and res_valid_out are a registered head; res_valid_out is high when the buffer is not empty.
  - A pop with res_ready_in high advances the head one entry per cycle.
  - When the last entry is popped, go to IDLE.
  - Host words are ignored until IDLE. A START_WORD arriving on the final-pop cycle is also ignored.
- res_valid_out is 0 in IDLE, LOAD and RUN. No pops occur outside DRAIN.
- busy_out equals (state==LOAD or state==RUN).

Test Plan:
- DIM=4, K_MAX=8. Stream FFFFFFFF,5,7,1,1,4,1 -> query_out words 5,7,1,1; k_out=4; vertex_id_out=1; start_out pulses one cycle after the last word.
- Core returns ids 9,3,6,2 at 3,5,6,10 cycles after start_out, with res_ready_in=1 -> pops 9,3,6,2 in order; cycles_out=10; state_out sequence 1,2,3,0.
- Stream FFFFFFFF,5,7,FFFFFFFF,1,2,3,4,2,8 -> restart at the second marker; query_out=1,2,3,4; k_out=2; vertex_id_out=8.
- k word=20 -> k_out=8, k_clamped_out=1. The core sends 10 results -> only the first 8 are stored. Next frame with k=3 -> k_clamped_out=0.
- In DRAIN with 4 results, res_ready_in=1 on alternate cycles -> one pop per high cycle and head held otherwise. Host words during DRAIN change nothing; IDLE follows the 4th pop.
- Assert rst_in for one cycle during RUN after 2 results -> all outputs 0, state IDLE, no res_valid_out. A new full frame then works normally.
